// File: rtl/avalon_copy_master.sv
// avalon_copy_master: Avalon-MM master that copies a block of 32-bit words from one word range to another.
// Define AVALON_COPY_CHECKSUM_EN to add a 32-bit running sum of the copied words on port `checksum`.
module avalon_copy_master #(
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    input  logic              avm_waitrequest
`ifdef AVALON_COPY_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_count;
    logic [31:0]       r_data;
    logic              r_busy;
    logic              r_done;
    logic              r_rd;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;

    logic [2:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_src_nxt;
    logic [ADDR_W-1:0] w_dst_nxt;
    logic [LEN_W-1:0]  w_len_nxt;
    logic [LEN_W-1:0]  w_count_nxt;
    logic [31:0]       w_data_nxt;
    logic [LEN_W-1:0]  w_count_inc;
    logic [ADDR_W-1:0] w_src_inc;
    logic [ADDR_W-1:0] w_dst_inc;

    assign w_count_inc = r_count + {{(LEN_W-1){1'b0}}, 1'b1};
    assign w_src_inc   = r_src + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign w_dst_inc   = r_dst + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Next-state, pointer, counter and data-register logic
    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        w_len_nxt   = r_len;
        w_count_nxt = r_count;
        w_data_nxt  = r_data;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_src_nxt   = src_addr;
                    w_dst_nxt   = dst_addr;
                    w_len_nxt   = length;
                    w_count_nxt = {LEN_W{1'b0}};
                    w_state_nxt = (length == {LEN_W{1'b0}}) ? S_DONE : S_READ;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_READ: begin
                if (!avm_waitrequest) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_READ;
                end
            end
            S_WAIT: begin
                if (avm_readdatavalid) begin
                    w_data_nxt  = avm_readdata;
                    w_state_nxt = S_WRITE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WRITE: begin
                if (!avm_waitrequest) begin
                    w_src_nxt   = w_src_inc;
                    w_dst_nxt   = w_dst_inc;
                    w_count_nxt = w_count_inc;
                    w_state_nxt = (w_count_inc == r_len) ? S_DONE : S_READ;
                end else begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and registered bus outputs, all derived from the upcoming state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_src   <= {ADDR_W{1'b0}};
            r_dst   <= {ADDR_W{1'b0}};
            r_len   <= {LEN_W{1'b0}};
            r_count <= {LEN_W{1'b0}};
            r_data  <= 32'h0000_0000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= {ADDR_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
            r_dst   <= w_dst_nxt;
            r_len   <= w_len_nxt;
            r_count <= w_count_nxt;
            r_data  <= w_data_nxt;
            r_busy  <= (w_state_nxt == S_READ) || (w_state_nxt == S_WAIT) || (w_state_nxt == S_WRITE);
            r_done  <= (w_state_nxt == S_DONE);
            r_rd    <= (w_state_nxt == S_READ);
            r_wr    <= (w_state_nxt == S_WRITE);
            r_addr  <= (w_state_nxt == S_READ)  ? w_src_nxt :
                       (w_state_nxt == S_WRITE) ? w_dst_nxt : r_addr;
        end
    end

`ifdef AVALON_COPY_CHECKSUM_EN
    logic [31:0] r_sum;
    logic [31:0] w_sum_nxt;

    // Running sum: cleared on an accepted start, accumulates every captured read word
    always_comb begin
        w_sum_nxt = r_sum;
        if ((r_state == S_IDLE) && start) begin
            w_sum_nxt = 32'h0000_0000;
        end else if ((r_state == S_WAIT) && avm_readdatavalid) begin
            w_sum_nxt = r_sum + avm_readdata;
        end else begin
            w_sum_nxt = r_sum;
        end
    end

    // Checksum register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum <= 32'h0000_0000;
        end else begin
            r_sum <= w_sum_nxt;
        end
    end

    assign checksum = r_sum;
`endif

    assign busy           = r_busy;
    assign done           = r_done;
    assign avm_address    = r_addr;
    assign avm_read       = r_rd;
    assign avm_write      = r_wr;
    assign avm_writedata  = r_data;
    assign avm_byteenable = 4'hF;

endmodule

// File: tb/tb_avalon_copy_master.sv
// tb_avalon_copy_master: directed and randomized copies against a bench-side memory slave and copy model.
// Build with AVALON_COPY_CHECKSUM_EN defined to also check the checksum port.
module tb_avalon_copy_master;

    logic        clk;
    logic        reset;
    logic        start;
    logic [10:0] src_addr;
    logic [10:0] dst_addr;
    logic [11:0] length;
    logic        busy;
    logic        done;
    logic [10:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        avm_waitrequest;
`ifdef AVALON_COPY_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    avalon_copy_master #(.ADDR_W(11), .LEN_W(12)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .src_addr          (src_addr),
        .dst_addr          (dst_addr),
        .length            (length),
        .busy              (busy),
        .done              (done),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_waitrequest   (avm_waitrequest)
`ifdef AVALON_COPY_CHECKSUM_EN
        ,
        .checksum          (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks   = 0;
    int failures = 0;

    // slave memory and the bench's own expected memory image
    logic [31:0] mem     [0:2047];
    logic [31:0] exp_mem [0:2047];
    int rd_log[$];
    int wr_log[$];
    int cfg_stalls, cfg_lat, stall_left, pend_cnt, pend_addr;
    int mon_err  = 0;
    int req_seen = 0;
    bit          prev_stalled, prev_rd, prev_wr;
    logic [10:0] prev_addr;
    logic [31:0] prev_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // One clock: at the falling edge, play the memory slave and watch the bus
    task automatic tick();
        @(negedge clk);
        if (reset) begin
            pend_cnt          = 0;
            stall_left        = cfg_stalls;
            prev_stalled      = 1'b0;
            avm_readdatavalid = 1'b0;
            avm_waitrequest   = 1'b0;
        end else begin
            if (avm_read && avm_write) mon_err++;
            if (prev_stalled && (avm_read !== prev_rd || avm_write !== prev_wr ||
                avm_address !== prev_addr || (avm_write && avm_writedata !== prev_wd))) mon_err++;
            avm_readdatavalid = 1'b0;
            if (pend_cnt == 0) begin
                // spurious valid pulses while no read is outstanding must be ignored
                if ($urandom_range(0, 3) == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = $urandom;
                end
            end else begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = mem[pend_addr];
                end
            end
            if (avm_read || avm_write) begin
                req_seen++;
                prev_rd   = avm_read;
                prev_wr   = avm_write;
                prev_addr = avm_address;
                prev_wd   = avm_writedata;
                if (stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    stall_left--;
                    prev_stalled = 1'b1;
                end else begin
                    avm_waitrequest = 1'b0;
                    prev_stalled    = 1'b0;
                    stall_left      = cfg_stalls;
                    if (avm_read) begin
                        pend_cnt  = cfg_lat;
                        pend_addr = int'(avm_address);
                        rd_log.push_back(int'(avm_address));
                    end else begin
                        mem[avm_address] = avm_writedata;
                        wr_log.push_back(int'(avm_address));
                    end
                end
            end else begin
                avm_waitrequest = 1'b0;
                prev_stalled    = 1'b0;
            end
        end
    endtask

    // Start a copy, follow it cycle by cycle and compare with the copy model
    task automatic run_copy(input string tag, input int src, input int dst, input int len,
                            input int stalls, input int lat, input int glitch_cyc, input int rst_cyc);
        int exp_rd[$];
        int exp_wr[$];
        logic [31:0] exp_sum;
        logic [31:0] sum_at_done;
        int exp_done, done_cyc, done_cnt, busy_cnt, busy_last, req0, diff, limit, s, d;
        bit ok;
        cfg_stalls = stalls;
        cfg_lat    = lat;
        stall_left = stalls;
        exp_sum    = 32'h0;
        sum_at_done = 32'h0;
        for (int i = 0; i < len; i++) begin
            s = (src + i) % 2048;
            d = (dst + i) % 2048;
            exp_rd.push_back(s);
            exp_wr.push_back(d);
            exp_sum    = exp_sum + exp_mem[s];
            exp_mem[d] = exp_mem[s];
        end
        exp_done = 1 + len * (2 + 2 * stalls + lat);
        rd_log.delete();
        wr_log.delete();
        req0      = req_seen;
        done_cyc  = -1;
        done_cnt  = 0;
        busy_cnt  = 0;
        busy_last = 0;
        src_addr  = 11'(src);
        dst_addr  = 11'(dst);
        length    = 12'(len);
        start     = 1'b1;
        limit = (rst_cyc > 0) ? rst_cyc + 4 : exp_done + 2;
        for (int c = 1; c <= limit; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (busy) begin
                busy_cnt++;
                busy_last = c;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
`ifdef AVALON_COPY_CHECKSUM_EN
                    sum_at_done = checksum;
`endif
                end
            end
            if (c == glitch_cyc) begin
                start    = 1'b1;
                src_addr = 11'($urandom);
                dst_addr = 11'($urandom);
                length   = 12'd0;
            end else if (c == glitch_cyc + 1) begin
                start = 1'b0;
            end
            if (rst_cyc > 0 && c == rst_cyc) begin
                chk({tag, "_write_before_reset"}, 32'(avm_write), 32'h1);
                reset = 1'b1;
            end
            if (rst_cyc > 0 && c == rst_cyc + 1) begin
                chk({tag, "_write_after_reset"}, 32'(avm_write), 32'h0);
                chk({tag, "_read_after_reset"}, 32'(avm_read), 32'h0);
                chk({tag, "_busy_after_reset"}, 32'(busy), 32'h0);
                reset = 1'b0;
            end
        end
        if (rst_cyc > 0) begin
            chk({tag, "_no_done"}, 32'(done_cnt), 32'h0);
            for (int i = 0; i < 2048; i++) exp_mem[i] = mem[i];
        end else begin
            chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
            chk({tag, "_done_pulses"}, 32'(done_cnt), 32'h1);
            chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_done - 1));
            if (len > 0) chk({tag, "_busy_last"}, 32'(busy_last), 32'(exp_done - 1));
            chk({tag, "_requests"}, 32'(req_seen - req0), 32'(2 * len * (1 + stalls)));
            ok = (rd_log.size() == exp_rd.size());
            for (int i = 0; i < rd_log.size(); i++) if (ok && rd_log[i] != exp_rd[i]) ok = 1'b0;
            chk({tag, "_read_order"}, 32'(ok), 32'h1);
            ok = (wr_log.size() == exp_wr.size());
            for (int i = 0; i < wr_log.size(); i++) if (ok && wr_log[i] != exp_wr[i]) ok = 1'b0;
            chk({tag, "_write_order"}, 32'(ok), 32'h1);
            diff = 0;
            for (int i = 0; i < 2048; i++) if (mem[i] !== exp_mem[i]) diff++;
            chk({tag, "_mem_words_wrong"}, 32'(diff), 32'h0);
`ifdef AVALON_COPY_CHECKSUM_EN
            chk({tag, "_checksum_at_done"}, sum_at_done, exp_sum);
            chk({tag, "_checksum_after"}, checksum, exp_sum);
`endif
        end
    endtask

    initial begin
        int rs, rd, rl;
        reset = 1'b1;
        start = 1'b0;
        src_addr = 11'd0;
        dst_addr = 11'd0;
        length   = 12'd0;
        avm_readdata      = 32'h0;
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;
        cfg_stalls = 0;
        cfg_lat    = 1;
        stall_left = 0;
        pend_cnt   = 0;
        pend_addr  = 0;
        prev_stalled = 1'b0;
        prev_rd = 1'b0;
        prev_wr = 1'b0;
        prev_addr = 11'd0;
        prev_wd = 32'h0;
        for (int i = 0; i < 2048; i++) begin
            mem[i]     = $urandom;
            exp_mem[i] = mem[i];
        end
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_read", 32'(avm_read), 32'h0);
        chk("rst_write", 32'(avm_write), 32'h0);
        chk("rst_address", 32'(avm_address), 32'h0);
        chk("rst_writedata", avm_writedata, 32'h0);
        chk("rst_byteenable", 32'(avm_byteenable), 32'hF);
`ifdef AVALON_COPY_CHECKSUM_EN
        chk("rst_checksum", checksum, 32'h0);
`endif
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            mem[10 + i]     = 32'(i + 1);
            exp_mem[10 + i] = 32'(i + 1);
        end
        run_copy("zero_wait", 10, 100, 4, 0, 1, 0, 0);
        chk("zero_wait_word103", mem[103], 32'h4);
        run_copy("stall2", 500, 600, 2, 2, 1, 0, 0);
        run_copy("wrap", 2046, 5, 4, 0, 1, 0, 0);
        run_copy("len0", 7, 9, 0, 0, 1, 0, 0);
        run_copy("start_in_busy", 20, 40, 4, 0, 1, 5, 0);
        run_copy("start_in_done", 60, 80, 2, 1, 2, 13, 0);
        run_copy("reset_in_write", 200, 220, 3, 0, 1, 0, 6);
        run_copy("after_reset", 230, 240, 1, 0, 1, 0, 0);
`ifdef AVALON_COPY_CHECKSUM_EN
        mem[300] = 32'hFFFF_FFFF;
        mem[301] = 32'h0000_0002;
        exp_mem[300] = 32'hFFFF_FFFF;
        exp_mem[301] = 32'h0000_0002;
        run_copy("csum", 300, 400, 2, 0, 1, 0, 0);
        chk("csum_literal", checksum, 32'h0000_0001);
`endif
        for (int k = 0; k < 8; k++) begin
            rs = $urandom_range(0, 2047);
            rd = (k % 2 == 0) ? (rs + $urandom_range(0, 3)) % 2048 : $urandom_range(0, 2047);
            rl = $urandom_range(1, 6);
            run_copy($sformatf("rand%0d", k), rs, rd, rl, $urandom_range(0, 2), $urandom_range(1, 3), 0, 0);
        end
        chk("bus_protocol_violations", 32'(mon_err), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
